// File: rtl/spi_tx_queue_if.sv
// Handshake bundle between control logic / SPI master and the MOSI byte queue.
// The AFULL signal exists only when SPI_TXQ_AFULL_EN is defined.
interface spi_tx_queue_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    logic                       FLUSH;
    logic                       WR_EN;
    logic [DATA_W-1:0]          WR_DATA;
    logic                       BYTE_TAKE;
    logic                       CLR_ERR;
    logic [DATA_W-1:0]          MOSI_data;
    logic                       BYTE_VALID;
    logic                       EMPTY;
    logic                       FULL;
    logic [$clog2(DEPTH):0]     COUNT;
    logic                       OVERFLOW;
    logic                       UNDERFLOW;
`ifdef SPI_TXQ_AFULL_EN
    logic                       AFULL;
`endif

    modport master (
        output FLUSH, WR_EN, WR_DATA, BYTE_TAKE, CLR_ERR,
        input  MOSI_data, BYTE_VALID, EMPTY, FULL, COUNT, OVERFLOW, UNDERFLOW
`ifdef SPI_TXQ_AFULL_EN
        , input AFULL
`endif
    );

    modport slave (
        input  FLUSH, WR_EN, WR_DATA, BYTE_TAKE, CLR_ERR,
        output MOSI_data, BYTE_VALID, EMPTY, FULL, COUNT, OVERFLOW, UNDERFLOW
`ifdef SPI_TXQ_AFULL_EN
        , output AFULL
`endif
    );
endinterface

// File: rtl/spi_tx_queue.sv
// First-word-fall-through MOSI byte queue with occupancy and sticky error flags.
// Define SPI_TXQ_AFULL_EN to add the registered almost-full output AFULL.
module spi_tx_queue #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 12
) (
    input logic          CTRL_CLK,
    input logic          RST,
    spi_tx_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("spi_tx_queue: DEPTH must be a power of two >= 2");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic              ovf;
    logic              udf;
    logic              empty;
    logic              full;
    logic              wr_acc;
    logic              rd_acc;
    logic              wr_bad;
    logic              rd_bad;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Accepts and error events use pre-edge state; FLUSH swallows both strobes.
    always_comb begin
        wr_acc     = bus.WR_EN && !full && !bus.FLUSH;
        rd_acc     = bus.BYTE_TAKE && !empty && !bus.FLUSH;
        wr_bad     = bus.WR_EN && full && !bus.FLUSH;
        rd_bad     = bus.BYTE_TAKE && empty && !bus.FLUSH;
        count_next = count + CW'(wr_acc) - CW'(rd_acc);
    end

    always_ff @(posedge CTRL_CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    // A new error event beats CLR_ERR in the same cycle.
    always_ff @(posedge CTRL_CLK or posedge RST) begin
        if (RST) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (wr_bad)           ovf <= 1'b1;
            else if (bus.CLR_ERR) ovf <= 1'b0;
            if (rd_bad)           udf <= 1'b1;
            else if (bus.CLR_ERR) udf <= 1'b0;
        end
    end

    // Storage is data only; stale contents are unreachable once pointers reset.
    always_ff @(posedge CTRL_CLK) begin
        if (wr_acc) mem[wr_ptr] <= bus.WR_DATA;
    end

    assign bus.COUNT      = count;
    assign bus.EMPTY      = empty;
    assign bus.FULL       = full;
    assign bus.BYTE_VALID = !empty;
    assign bus.MOSI_data  = empty ? '0 : mem[rd_ptr];
    assign bus.OVERFLOW   = ovf;
    assign bus.UNDERFLOW  = udf;

`ifdef SPI_TXQ_AFULL_EN
    if (AFULL_LVL < 1 || AFULL_LVL > DEPTH - 1) begin : g_bad_lvl
        $error("spi_tx_queue: AFULL_LVL must be in 1..DEPTH-1");
    end

    logic afull;

    always_ff @(posedge CTRL_CLK or posedge RST) begin
        if (RST)            afull <= 1'b0;
        else if (bus.FLUSH) afull <= 1'b0;
        else                afull <= (count_next >= CW'(AFULL_LVL));
    end

    assign bus.AFULL = afull;
`endif
endmodule
